// File: rtl/control_rx_in_pkg.sv
// -----------------------------------------------------------------------------
// ControlRx_in -- shared receive-path data types.
//
// Purpose : common scalar/byte types used by the receive-side blocks so that
//           every module agrees on the width of a received character.
// Contents: DataIn_t (one received byte), One_t (single control bit).
// -----------------------------------------------------------------------------
package ControlRx_in;

   typedef logic [7:0] DataIn_t;
   typedef logic       One_t;

endpackage : ControlRx_in

// File: rtl/uart_rx_in_pkg.sv
// -----------------------------------------------------------------------------
// UartRx_pkg -- types and constants for the uart_rx_in receiver.
//
// Purpose : receiver FSM state encoding, baud counter width and the default
//           divider for a 50 MHz clock at 115200 baud.
// Config  : UART_RX_PARITY_EN adds the PARITY state to the state encoding.
// -----------------------------------------------------------------------------
package UartRx_pkg;

   import ControlRx_in::*;

   // Baud counter width; wide enough for any divider up to 65535.
   localparam int CNT_W            = 16;
   // 50 MHz / 115200 baud.
   localparam int BAUD_DIV_DEFAULT = 434;

   typedef logic [CNT_W-1:0] BaudCnt_t;

   // Encodings are fixed so the debug state value is stable between builds
   // with and without parity.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } UartRxState_t;

   // Even parity: the transmitted parity bit makes the total count of ones
   // (data plus parity) even, so the expected bit is the XOR of the data.
   function automatic One_t even_parity(input DataIn_t d);
      return ^d;
   endfunction

endpackage : UartRx_pkg

// File: rtl/uart_rx_in_if.sv
// -----------------------------------------------------------------------------
// uart_rx_in_if -- serial line and received-byte signals of the receiver.
//
// Handshake: there is no back-pressure. DataReady_Rx is a single-cycle strobe
// meaning "DataRecive_Rx now holds a new valid byte"; the consumer must take
// it in that cycle. FrameError / ParityError are single-cycle strobes that
// report a rejected frame. DataRecive_Rx is stable between strobes.
//
// Signals:
//   SerialIn       UART line into the receiver (idle high, asynchronous)
//   DataReady_Rx   one-cycle pulse, new byte available
//   DataRecive_Rx  last valid received byte
//   FrameError     one-cycle pulse, stop bit sampled low
//   ParityError    one-cycle pulse, parity mismatch (0 without parity build)
//
// Modports: slave = the receiver, master = the line driver / byte consumer.
// -----------------------------------------------------------------------------
interface uart_rx_in_if;

   import ControlRx_in::*;

   One_t    SerialIn;
   One_t    DataReady_Rx;
   DataIn_t DataRecive_Rx;
   One_t    FrameError;
   One_t    ParityError;

   modport slave (
      input  SerialIn,
      output DataReady_Rx,
      output DataRecive_Rx,
      output FrameError,
      output ParityError
   );

   modport master (
      output SerialIn,
      input  DataReady_Rx,
      input  DataRecive_Rx,
      input  FrameError,
      input  ParityError
   );

endinterface : uart_rx_in_if

// File: rtl/uart_rx_in_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync -- two-flop synchronizer for the asynchronous UART line.
//
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset; both flops go to 1 (idle line)
//   d      asynchronous input
//   q      synchronized output, two clock cycles of latency
// -----------------------------------------------------------------------------
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Reset to 1 so a reset never looks like a falling edge on the line.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule : uart_rx_sync

// File: rtl/uart_rx_in.sv
// -----------------------------------------------------------------------------
// uart_rx_in -- UART receiver, 8 data bits LSB first, one stop bit.
//
// Purpose : oversamples the line with a BAUD_DIV-cycle baud counter, samples
//           each bit at its middle, and presents each good byte with a
//           one-cycle DataReady_Rx strobe. Bad frames produce FrameError /
//           ParityError strobes and leave the output byte untouched.
// Config  : define UART_RX_PARITY_EN for 8E1 framing (even parity bit after
//           bit 7). Default build is 8N1 with ParityError tied low.
// Params  : BAUD_DIV  clock cycles per serial bit (8..65535)
// Ports   :
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   rx         uart_rx_in_if.slave (SerialIn in; byte and strobes out)
//   state_dbg  current receiver state, for observation only
// -----------------------------------------------------------------------------
module uart_rx_in
   import ControlRx_in::*;
   import UartRx_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   uart_rx_in_if.slave  rx,
   output UartRxState_t state_dbg
);

   // Compare points of the baud counter: half a bit for the start-bit
   // qualification, a full bit for every later sample.
   localparam BaudCnt_t MID_CNT  = BaudCnt_t'(BAUD_DIV / 2 - 1);
   localparam BaudCnt_t LAST_CNT = BaudCnt_t'(BAUD_DIV - 1);

   One_t rx_s;

   UartRxState_t state_q, state_n;
   BaudCnt_t     cnt_q,   cnt_n;
   logic [2:0]   bit_q,   bit_n;
   DataIn_t      shift_q, shift_n;
   DataIn_t      data_q,  data_n;
   One_t         ready_q, ready_n;
   One_t         ferr_q,  ferr_n;
`ifdef UART_RX_PARITY_EN
   One_t         perr_q,    perr_n;
   One_t         par_bad_q, par_bad_n;
`endif

   uart_rx_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx.SerialIn),
      .q     (rx_s)
   );

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         ready_q   <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q    <= 1'b0;
         par_bad_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         bit_q     <= bit_n;
         shift_q   <= shift_n;
         data_q    <= data_n;
         ready_q   <= ready_n;
         ferr_q    <= ferr_n;
`ifdef UART_RX_PARITY_EN
         perr_q    <= perr_n;
         par_bad_q <= par_bad_n;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_n   = state_q;
      cnt_n     = cnt_q;
      bit_n     = bit_q;
      shift_n   = shift_q;
      data_n    = data_q;
      ready_n   = 1'b0;
      ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_n    = 1'b0;
      par_bad_n = par_bad_q;
`endif

      unique case (state_q)
         IDLE: begin
            // Counter is held at zero so START measures from the edge.
            cnt_n = '0;
            if (!rx_s) begin
               state_n = START;
`ifdef UART_RX_PARITY_EN
               par_bad_n = 1'b0;
`endif
            end
         end

         START: begin
            if (cnt_q == MID_CNT) begin
               // Line back high by mid start bit means it was a glitch.
               cnt_n   = '0;
               bit_n   = '0;
               state_n = rx_s ? IDLE : DATA;
            end else begin
               cnt_n = cnt_q + BaudCnt_t'(1);
            end
         end

         DATA: begin
            if (cnt_q == LAST_CNT) begin
               cnt_n   = '0;
               shift_n = {rx_s, shift_q[7:1]};
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  bit_n = bit_q + 3'd1;
               end
            end else begin
               cnt_n = cnt_q + BaudCnt_t'(1);
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_q == LAST_CNT) begin
               cnt_n     = '0;
               par_bad_n = (rx_s != even_parity(shift_q));
               state_n   = STOP;
            end else begin
               cnt_n = cnt_q + BaudCnt_t'(1);
            end
         end
`endif

         STOP: begin
            if (cnt_q == LAST_CNT) begin
               // Leave at mid stop bit so a back-to-back start edge is seen.
               cnt_n   = '0;
               state_n = IDLE;
               if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                  if (!par_bad_q) begin
                     data_n  = shift_q;
                     ready_n = 1'b1;
                  end
`else
                  data_n  = shift_q;
                  ready_n = 1'b1;
`endif
               end else begin
                  ferr_n = 1'b1;
               end
`ifdef UART_RX_PARITY_EN
               perr_n = par_bad_q;
`endif
            end else begin
               cnt_n = cnt_q + BaudCnt_t'(1);
            end
         end

         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign rx.DataReady_Rx  = ready_q;
   assign rx.DataRecive_Rx = data_q;
   assign rx.FrameError    = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign rx.ParityError   = perr_q;
`else
   assign rx.ParityError   = 1'b0;
`endif
   assign state_dbg        = state_q;

endmodule : uart_rx_in

// File: doc/uart_rx_in.md
UART_RX_IN -- requirements
Module: uart_rx_in

Interface
REQ-001 Parameter: BAUD_DIV, 434, clock cycles per serial bit (50 MHz / 115200); legal range 8..65535.
REQ-002 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: SerialIn  input  1  asynchronous UART line, idle high.
REQ-005 Port: DataReady_Rx  output  1  one-cycle pulse; a valid byte is on DataRecive_Rx.
REQ-006 Port: DataRecive_Rx  output  8 (DataIn_t)  last valid received byte.
REQ-007 Port: FrameError  output  1  one-cycle pulse; stop bit sampled low.
REQ-008 Port: ParityError  output  1  one-cycle pulse; parity mismatch.

Function
REQ-009 SerialIn SHALL pass a 2-flop synchronizer; all decisions use the synchronized value.
REQ-010 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-011 IDLE: on the synchronized line low, clear the baud counter and go to START.
REQ-012 START: at count BAUD_DIV/2-1 (mid start bit), the line low goes to DATA; the line high (glitch) returns to IDLE with no pulse.
REQ-013 DATA: sample every BAUD_DIV cycles, LSB first, into a shift register; after bit 7 go to PARITY if enabled, else STOP.
REQ-014 The baud counter SHALL be 16-bit, count 0..BAUD_DIV-1, and wrap to 0 on each sample.
REQ-015 STOP: at mid stop bit, a high line loads DataRecive_Rx and pulses DataReady_Rx for exactly one cycle on the next edge; a low line pulses FrameError and leaves DataRecive_Rx unchanged.
REQ-016 After the STOP sample, return to IDLE immediately (mid stop bit) so back-to-back frames are accepted.
REQ-017 A low line in IDLE right after a framing error SHALL be treated as a new start bit, with no break detection.
REQ-018 Parity error SHALL suppress DataReady_Rx, pulse ParityError, and still check the stop bit; FrameError and ParityError MAY pulse in the same cycle.
REQ-019 DataReady_Rx SHALL never pulse in two consecutive cycles; minimum spacing is one frame.
REQ-020 DataRecive_Rx SHALL hold its value until the next valid byte.

Reset
REQ-021 Reset SHALL force IDLE, counter 0, shift register 0, DataRecive_Rx 8'h00, and DataReady_Rx/FrameError/ParityError 0 on the same edge.
REQ-022 Synchronizer flops SHALL reset to 1 (idle line).
REQ-023 Reset mid-frame SHALL abort the frame with no pulse; reception resumes at the next falling edge after reset deasserts.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: one even-parity bit follows bit 7, handled in PARITY at mid-bit; mismatch per REQ-018.
REQ-025 Macro undefined: the PARITY state and logic are absent, the frame is 8N1, and ParityError is tied 0.

Structure
REQ-026 Package UartRx_pkg SHALL hold the UartRxState_t enum, the counter width constant (16), and the BAUD_DIV default; DataIn_t/One_t come from the existing ControlRx_in package.
REQ-027 One sub-module, uart_rx_sync (2-flop synchronizer, reset value 1), SHALL be instantiated; the rest is flat.

Verification (BAUD_DIV=16 in sim)
REQ-028 8N1 frame 0xA5 -> DataReady_Rx is high one cycle at about 9.5 bit times after the start edge, and DataRecive_Rx==8'hA5.
REQ-029 Frames 0xFE then 0x03 back-to-back with no idle gap -> two DataReady_Rx pulses, with values 8'hFE and 8'h03.
REQ-030 Low glitch of 4 cycles on the idle line -> no pulses; state returns to IDLE.
REQ-031 Frame 0x3C with stop bit forced low -> FrameError pulses once, DataReady_Rx stays 0, and DataRecive_Rx keeps its prior value.
REQ-032 With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> ParityError pulse and no DataReady_Rx; with correct parity 1 -> DataReady_Rx pulse with 8'h07.
REQ-033 reset asserted at data bit 4 of 0x55 -> no pulses and all outputs 0; the next full frame 0x81 is received correctly.
